hdmi_timing: RTL

HDMI_TIMING -- requirements
Module: hdmi_timing

---
 rtl/hdmi_pkg.sv | 28 ++
 rtl/sig_delay.sv | 31 +++
 rtl/hdmi_timing.sv | 107 ++++++++++
 3 files changed

// File: rtl/hdmi_pkg.sv
// Shared 480p timing constants and the packed {de, hsync, vsync} control word
// carried through the alignment delay.
package hdmi_pkg;

    localparam int SCREEN_W_480P  = 720;
    localparam int SCREEN_H_480P  = 480;
    localparam int FRAME_W_480P   = 858;
    localparam int FRAME_H_480P   = 525;
    localparam int HSYNC_S_480P   = 736;
    localparam int HSYNC_E_480P   = 798;
    localparam int VSYNC_S_480P   = 489;
    localparam int VSYNC_E_480P   = 495;

    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
    } sync_t;

    function automatic sync_t sync_idle(input logic sync_on);
        sync_t s;
        s.de    = 1'b0;
        s.hsync = ~sync_on;
        s.vsync = ~sync_on;
        return s;
    endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift register with a parameterised reset value; depth 0 is a
// straight wire.
module sig_delay #(
    parameter int                DATA_W  = 1,
    parameter int                STAGES  = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_h,
    input  logic              rst_h,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    if (STAGES == 0) begin : g_wire
        assign dout = din;
    end else begin : g_pipe
        logic [DATA_W-1:0] pipe [STAGES];

        always_ff @(posedge clk_h) begin
            if (rst_h) begin
                for (int i = 0; i < STAGES; i++) pipe[i] <= RST_VAL;
            end else begin
                pipe[0] <= din;
                for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
            end
        end

        assign dout = pipe[STAGES-1];
    end

endmodule

// File: rtl/hdmi_timing.sv
// Free-running raster counters for the HDMI output, with de/sync delayed to line
// up with the upstream pixel fetch and blanking forced to black.
module hdmi_timing
    import hdmi_pkg::*;
#(
    parameter int OSCREEN_WIDTH  = SCREEN_W_480P,
    parameter int OSCREEN_HEIGHT = SCREEN_H_480P,
    parameter int OFRAME_WIDTH   = FRAME_W_480P,
    parameter int OFRAME_HEIGHT  = FRAME_H_480P,
    parameter int HSYNC_START    = HSYNC_S_480P,
    parameter int HSYNC_END      = HSYNC_E_480P,
    parameter int VSYNC_START    = VSYNC_S_480P,
    parameter int VSYNC_END      = VSYNC_E_480P,
    parameter int SYNC_ACTIVE    = 0,
    parameter int PIXEL_LATENCY  = 2
) (
    input  logic        clk_h,
    input  logic        rst_h,
    output logic [9:0]  hx,
    output logic [9:0]  hy,
    output logic        new_frame,
    input  logic [23:0] rgb_h,
    output logic [23:0] rgb_o,
    output logic        de_o,
    output logic        hsync_o,
    output logic        vsync_o
);

    if (!(OSCREEN_WIDTH >= 1 && OSCREEN_WIDTH <= HSYNC_START &&
          HSYNC_START < HSYNC_END && HSYNC_END <= OFRAME_WIDTH &&
          OFRAME_WIDTH <= 1024 &&
          OSCREEN_HEIGHT >= 1 && OSCREEN_HEIGHT <= VSYNC_START &&
          VSYNC_START < VSYNC_END && VSYNC_END <= OFRAME_HEIGHT &&
          OFRAME_HEIGHT <= 1024 &&
          PIXEL_LATENCY >= 0 && PIXEL_LATENCY <= 8)) begin : g_bad_params
        $fatal(1, "hdmi_timing: illegal timing parameters");
    end

    // Inclusive upper bounds keep every compare inside 10 bits even at 1024.
    localparam logic [9:0] HX_LAST   = 10'(OFRAME_WIDTH - 1);
    localparam logic [9:0] HY_LAST   = 10'(OFRAME_HEIGHT - 1);
    localparam logic [9:0] DE_X_LAST = 10'(OSCREEN_WIDTH - 1);
    localparam logic [9:0] DE_Y_LAST = 10'(OSCREEN_HEIGHT - 1);
    localparam logic [9:0] HS_FIRST  = 10'(HSYNC_START);
    localparam logic [9:0] HS_LAST   = 10'(HSYNC_END - 1);
    localparam logic [9:0] VS_FIRST  = 10'(VSYNC_START);
    localparam logic [9:0] VS_LAST   = 10'(VSYNC_END - 1);
    localparam logic       SYNC_ON   = (SYNC_ACTIVE != 0);
    localparam sync_t      SYNC_IDLE = sync_idle(SYNC_ON);

    sync_t sync_p0;
    sync_t sync_p1;
    sync_t sync_p2;

    // Stage 0: raster counters; new_frame is registered from the pre-wrap state.
    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            hx        <= '0;
            hy        <= '0;
            new_frame <= 1'b0;
        end else begin
            hx        <= (hx == HX_LAST) ? 10'd0 : hx + 10'd1;
            if (hx == HX_LAST) hy <= (hy == HY_LAST) ? 10'd0 : hy + 10'd1;
            new_frame <= (hx == HX_LAST - 10'd1) && (hy == HY_LAST);
        end
    end

    always_comb begin
        sync_p0.de    = (hx <= DE_X_LAST) && (hy <= DE_Y_LAST);
        sync_p0.hsync = (hx >= HS_FIRST && hx <= HS_LAST) ? SYNC_ON : ~SYNC_ON;
        sync_p0.vsync = (hy >= VS_FIRST && hy <= VS_LAST) ? SYNC_ON : ~SYNC_ON;
    end

    // Stage 1: align control with the pixel returned PIXEL_LATENCY clocks later.
    sig_delay #(
        .DATA_W ($bits(sync_t)),
        .STAGES (PIXEL_LATENCY),
        .RST_VAL(SYNC_IDLE)
    ) u_align (
        .clk_h(clk_h),
        .rst_h(rst_h),
        .din  (sync_p0),
        .dout (sync_p1)
    );

    // Stage 2: output register shared by control and pixel.
    sig_delay #(
        .DATA_W ($bits(sync_t)),
        .STAGES (1),
        .RST_VAL(SYNC_IDLE)
    ) u_out (
        .clk_h(clk_h),
        .rst_h(rst_h),
        .din  (sync_p1),
        .dout (sync_p2)
    );

    always_ff @(posedge clk_h) begin
        if (rst_h) rgb_o <= '0;
        else       rgb_o <= sync_p1.de ? rgb_h : 24'h0;
    end

    assign de_o    = sync_p2.de;
    assign hsync_o = sync_p2.hsync;
    assign vsync_o = sync_p2.vsync;

endmodule
